seg7_hex_counter_scan: RTL and testbench

Parametrised successor to the single-digit hex counter/7-segment tile. A synchronous, prescaled up/down hex counter of DIGITS nibbles, with load and a manual-display mode. A time-multiplexed scanner drives one shared 7-segment bus plus one-hot digit selects. It sits between the tile I/O pins and the segment/digit outputs.

---
 rtl/seg7_hex_counter_scan.sv | 140 ++++++++++++++
 tb/tb_seg7_hex_counter_scan.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_hex_counter_scan.sv
// Prescaled up/down hex counter of DIGITS nibbles with a multiplexed 7-segment scanner.
// Optional macro BLANK_LEADING_EN suppresses leading-zero digits (digit 0 always shown).
module seg7_hex_counter_scan #(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 4,
    parameter int SCAN_DIV = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  mode,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   manual_val,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]     presc_q, presc_d;
    logic [W-1:0]      count_q, count_d;
    logic              carry_q, carry_d;
    logic [SW-1:0]     scan_div_q, scan_div_d;
    logic [IW-1:0]     scan_idx_q, scan_idx_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [DIGITS-1:0] dig_sel_q, dig_sel_d;

    logic          advance;
    logic          tick;
    logic          strobe;
    logic          blank;
    logic [W-1:0]  disp_val;
    logic [3:0]    nibble;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Load wins over a coincident tick and restarts the prescale interval.
    always_comb begin
        advance = ena & ~mode & ~load;
        tick    = advance & (presc_q == PW'(PRESCALE - 1));
        presc_d = presc_q;
        count_d = count_q;
        carry_d = 1'b0;
        if (load) begin
            presc_d = '0;
            count_d = manual_val;
        end else if (advance) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                if (up_dn) begin
                    count_d = count_q + W'(1);
                    carry_d = &count_q;
                end else begin
                    count_d = count_q - W'(1);
                    carry_d = ~|count_q;
                end
            end
        end
    end

    always_comb begin
        strobe     = (scan_div_q == SW'(SCAN_DIV - 1));
        scan_div_d = strobe ? '0 : scan_div_q + SW'(1);
        scan_idx_d = scan_idx_q;
        seg_d      = seg_q;
        dp_d       = dp_q;
        dig_sel_d  = dig_sel_q;
        disp_val   = mode ? manual_val : count_q;
        nibble     = disp_val[4*scan_idx_q +: 4];
`ifdef BLANK_LEADING_EN
        blank      = (scan_idx_q != '0) && ((disp_val >> (4 * scan_idx_q)) == '0);
`else
        blank      = 1'b0;
`endif
        if (strobe) begin
            dig_sel_d  = DIGITS'(1) << scan_idx_q;
            seg_d      = blank ? 7'h00 : hex_to_seg(nibble);
            dp_d       = mode & (scan_idx_q == '0);
            scan_idx_d = (scan_idx_q == IW'(DIGITS - 1)) ? '0 : scan_idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            count_q    <= '0;
            carry_q    <= 1'b0;
            scan_div_q <= '0;
            scan_idx_q <= '0;
            seg_q      <= '0;
            dp_q       <= 1'b0;
            dig_sel_q  <= '0;
        end else begin
            presc_q    <= presc_d;
            count_q    <= count_d;
            carry_q    <= carry_d;
            scan_div_q <= scan_div_d;
            scan_idx_q <= scan_idx_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            dig_sel_q  <= dig_sel_d;
        end
    end

    assign seg     = seg_q;
    assign dp      = dp_q;
    assign dig_sel = dig_sel_q;
    assign count   = count_q;
    assign carry   = carry_q;

endmodule

// File: tb/tb_seg7_hex_counter_scan.sv
// Directed bench for seg7_hex_counter_scan at DIGITS=2, PRESCALE=4, SCAN_DIV=2.
module tb_seg7_hex_counter_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena, mode, up_dn, load;
    logic [7:0] manual_val;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] dig_sel;
    logic [7:0] count;
    logic       carry;

    int vecs = 0;
    int errs = 0;
    int cyc;

    seg7_hex_counter_scan #(.DIGITS(2), .PRESCALE(4), .SCAN_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .up_dn(up_dn),
        .load(load), .manual_val(manual_val), .seg(seg), .dp(dp),
        .dig_sel(dig_sel), .count(count), .carry(carry)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; scan strobes land on even counts.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vecs++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_phase(input int r);
        int k = 0;
        while ((cyc % 4) != r && k < 8) begin
            @(negedge clk);
            k++;
        end
    endtask

`ifdef BLANK_LEADING_EN
    localparam logic [6:0] SEG_D1_ZERO = 7'h00;
`else
    localparam logic [6:0] SEG_D1_ZERO = 7'h3F;
`endif

    initial begin
        rst_n = 1'b0; ena = 1'b0; mode = 1'b0; up_dn = 1'b1; load = 1'b0; manual_val = 8'h00;
        cyc_n(2);
        chk("rst_count",   count,   32'h00);
        chk("rst_seg",     seg,     32'h00);
        chk("rst_dig_sel", dig_sel, 32'h0);
        chk("rst_dp",      dp,      32'h0);
        chk("rst_carry",   carry,   32'h0);
        rst_n = 1'b1;

        // count to 0x37, then asynchronous reset between edges
        load = 1'b1; manual_val = 8'h36;
        cyc_n(1);
        chk("ld36", count, 32'h36);
        load = 1'b0; ena = 1'b1;
        cyc_n(3);
        chk("hold36", count, 32'h36);
        cyc_n(1);
        chk("to37", count, 32'h37);
        ena = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_count",   count,   32'h00);
        chk("async_seg",     seg,     32'h00);
        chk("async_dig_sel", dig_sel, 32'h0);
        chk("async_carry",   carry,   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc_n(1);
        chk("pre_strobe_dig", dig_sel, 32'h0);
        cyc_n(1);
        chk("first_strobe_dig", dig_sel, 32'h1);
        chk("first_strobe_seg", seg,     32'h3F);
        chk("first_strobe_dp",  dp,      32'h0);

        // up wrap FE -> FF -> 00
        load = 1'b1; manual_val = 8'hFE;
        cyc_n(1);
        chk("ldFE", count, 32'hFE);
        chk("ldFE_carry", carry, 32'h0);
        load = 1'b0; ena = 1'b1; up_dn = 1'b1;
        cyc_n(3);
        chk("up_hold_FE", count, 32'hFE);
        cyc_n(1);
        chk("up_FF", count, 32'hFF);
        chk("up_FF_carry", carry, 32'h0);
        cyc_n(3);
        chk("up_hold_FF", count, 32'hFF);
        cyc_n(1);
        chk("up_wrap_00", count, 32'h00);
        chk("up_wrap_carry", carry, 32'h1);
        cyc_n(1);
        chk("up_carry_drop", carry, 32'h0);
        chk("up_after_00", count, 32'h00);
        ena = 1'b0;

        // down wrap 01 -> 00 -> FF
        load = 1'b1; manual_val = 8'h01;
        cyc_n(1);
        load = 1'b0; up_dn = 1'b0; ena = 1'b1;
        cyc_n(4);
        chk("dn_00", count, 32'h00);
        chk("dn_00_carry", carry, 32'h0);
        cyc_n(4);
        chk("dn_wrap_FF", count, 32'hFF);
        chk("dn_wrap_carry", carry, 32'h1);
        cyc_n(1);
        chk("dn_carry_drop", carry, 32'h0);
        chk("dn_after_FF", count, 32'hFF);
        ena = 1'b0; up_dn = 1'b1;

        // load collides with a tick
        load = 1'b1; manual_val = 8'h50;
        cyc_n(1);
        load = 1'b0; ena = 1'b1;
        cyc_n(3);
        chk("coll_pre", count, 32'h50);
        load = 1'b1; manual_val = 8'h5A;
        cyc_n(1);
        chk("coll_load", count, 32'h5A);
        chk("coll_carry", carry, 32'h0);
        load = 1'b0;
        cyc_n(3);
        chk("coll_hold", count, 32'h5A);
        cyc_n(1);
        chk("coll_5B", count, 32'h5B);
        ena = 1'b0;

        // ena=0 freeze with partial prescale, scan keeps running
        load = 1'b1; manual_val = 8'h05;
        cyc_n(1);
        load = 1'b0; ena = 1'b1;
        cyc_n(2);
        ena = 1'b0;
        cyc_n(50);
        chk("frz_count_mid", count, 32'h05);
        wait_phase(2);
        chk("frz_d0_dig", dig_sel, 32'h1);
        chk("frz_d0_seg", seg,     32'h6D);
        chk("frz_d0_dp",  dp,      32'h0);
        cyc_n(2);
        chk("frz_d1_dig", dig_sel, 32'h2);
        chk("frz_d1_seg", seg,     {25'h0, SEG_D1_ZERO});
        cyc_n(48);
        chk("frz_count_end", count, 32'h05);
        ena = 1'b1;
        cyc_n(1);
        chk("frz_resume_hold", count, 32'h05);
        cyc_n(1);
        chk("frz_resume_06", count, 32'h06);

        // manual display mode, counter frozen even with ena=1
        mode = 1'b1; manual_val = 8'h3C;
        cyc_n(4);
        wait_phase(2);
        chk("man_d0_dig", dig_sel, 32'h1);
        chk("man_d0_seg", seg,     32'h39);
        chk("man_d0_dp",  dp,      32'h1);
        cyc_n(1);
        chk("man_d0_hold", dig_sel, 32'h1);
        cyc_n(1);
        chk("man_d1_dig", dig_sel, 32'h2);
        chk("man_d1_seg", seg,     32'h4F);
        chk("man_d1_dp",  dp,      32'h0);
        cyc_n(2);
        chk("man_d0b_dig", dig_sel, 32'h1);
        chk("man_d0b_seg", seg,     32'h39);
        cyc_n(50);
        chk("man_count", count, 32'h06);
        chk("man_carry", carry, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
